// File: rtl/shift_seq_pkg.sv
// Shared encodings, widths and helpers for the shift_seq multi-cycle shifter.
package shift_seq_pkg;

  localparam int WORD = 32;
  localparam int SHW  = 5;

  typedef logic [WORD-1:0] word_t;
  typedef logic [SHW-1:0]  amt_t;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Only the low SHW bits of rs ever reach the shifter.
  function automatic amt_t sel_amt(input logic src_sel, input amt_t shamt, input word_t rs);
    return src_sel ? rs[SHW-1:0] : shamt;
  endfunction

endpackage

// File: rtl/shift_seq_if.sv
// EX-stage issue/result bundle between the pipeline (master) and shift_seq (slave).
interface shift_seq_if;
  import shift_seq_pkg::*;

  logic       start;
  logic       clr;
  logic [1:0] op;
  logic       src_sel;
  amt_t       shamt;
  word_t      rs;
  word_t      data_in;
  logic       busy;
  logic       done;
  word_t      result;

  modport master (
    output start, clr, op, src_sel, shamt, rs, data_in,
    input  busy, done, result
  );

  modport slave (
    input  start, clr, op, src_sel, shamt, rs, data_in,
    output busy, done, result
  );

endinterface

// File: rtl/shift_step.sv
// Combinational single-step shifter: SLL/SRL/SRA of acc by s, SRA filling with fill.
module shift_step
  import shift_seq_pkg::*;
(
  input  word_t      acc,
  input  amt_t       s,
  input  logic [1:0] op,
  input  logic       fill,
  output word_t      y
);

  localparam word_t ALL_ONES = '1;

  word_t sign_mask;

  assign sign_mask = fill ? ~(ALL_ONES >> s) : '0;

  always_comb begin
    case (op)
      SH_SRL:  y = acc >> s;
      SH_SRA:  y = (acc >> s) | sign_mask;
      default: y = acc << s;
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Iterative MIPS shift unit (SLL/SRL/SRA, variable forms), at most STEP bits per RUN cycle.
// Define SHIFT_FAST_EN to replace the iteration with a single full barrel shift.
module shift_seq
  import shift_seq_pkg::*;
#(
  parameter int STEP = 4
) (
  input logic        clk,
  input logic        reset,
  shift_seq_if.slave bus
);

  if (STEP < 1 || STEP > 31) begin : g_bad_step
    $error("shift_seq: STEP must be in 1..31");
  end

  localparam amt_t STEP_S = amt_t'(STEP);

  function automatic amt_t step_amt(input amt_t rem);
    return (rem < STEP_S) ? rem : STEP_S;
  endfunction

  logic [1:0] state_q, state_d;
  logic [1:0] op_q, op_d;
  logic       fill_q, fill_d;
  word_t      acc_q, acc_d;
  amt_t       rem_q, rem_d;
  word_t      result_q, result_d;
  logic       busy_q;
  logic       done_q;

  amt_t       amt;
  amt_t       run_s;
  amt_t       rem_left;

  word_t      st_acc;
  amt_t       st_s;
  logic [1:0] st_op;
  logic       st_fill;
  word_t      st_y;

  assign amt      = sel_amt(bus.src_sel, bus.shamt, bus.rs);
  assign run_s    = step_amt(rem_q);
  assign rem_left = rem_q - run_s;

  // The single shifter serves RUN iterations, or the whole shift at issue in fast mode.
  always_comb begin
    st_acc  = acc_q;
    st_s    = run_s;
    st_op   = op_q;
    st_fill = fill_q;
`ifdef SHIFT_FAST_EN
    if (state_q != ST_RUN) begin
      st_acc  = bus.data_in;
      st_s    = amt;
      st_op   = bus.op;
      st_fill = bus.data_in[WORD-1];
    end
`endif
  end

  shift_step u_step (
    .acc  (st_acc),
    .s    (st_s),
    .op   (st_op),
    .fill (st_fill),
    .y    (st_y)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    fill_d   = fill_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    result_d = result_q;
    if (bus.clr) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_RUN: begin
          acc_d = st_y;
          rem_d = rem_left;
          if (rem_left == '0) begin
            state_d  = ST_DONE;
            result_d = st_y;
          end
        end
        default: begin
          // IDLE and DONE both accept a new shift; DONE falls back to IDLE otherwise.
          state_d = ST_IDLE;
          if (bus.start) begin
            op_d   = bus.op;
            fill_d = bus.data_in[WORD-1];
`ifdef SHIFT_FAST_EN
            acc_d    = st_y;
            rem_d    = '0;
            state_d  = ST_DONE;
            result_d = st_y;
`else
            acc_d = bus.data_in;
            rem_d = amt;
            if (amt == '0) begin
              state_d  = ST_DONE;
              result_d = bus.data_in;
            end else begin
              state_d = ST_RUN;
            end
`endif
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= SH_SLL;
      fill_q   <= 1'b0;
      acc_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      fill_q   <= fill_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      busy_q   <= (state_d == ST_RUN);
      done_q   <= (state_d == ST_DONE);
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_shift_seq.sv
// Table-driven, hand-sequenced and randomized bench for shift_seq.
module tb_shift_seq;
  import shift_seq_pkg::*;

  localparam int STEP = 4;

  logic clk = 1'b0;
  logic reset;

  shift_seq_if bus ();

  shift_seq #(.STEP(STEP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  op;
    logic        src_sel;
    logic [4:0]  shamt;
    logic [31:0] rs;
    logic [31:0] din;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int amt);
`ifdef SHIFT_FAST_EN
    return 1;
`else
    return (amt == 0) ? 1 : 1 + (amt + STEP - 1) / STEP;
`endif
  endfunction

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input int amt, input logic [31:0] d);
    logic signed [31:0] sd;
    sd = d;
    case (op)
      2'b01:   return d >> amt;
      2'b10:   return sd >>> amt;
      default: return d << amt;
    endcase
  endfunction

  task automatic issue(input logic [1:0] op, input logic src, input logic [4:0] sh,
                       input logic [31:0] rs, input logic [31:0] din);
    bus.op      = op;
    bus.src_sel = src;
    bus.shamt   = sh;
    bus.rs      = rs;
    bus.data_in = din;
    bus.start   = 1'b1;
  endtask

  // Entered #1 after the start edge; lat counts cycles until done, bounded.
  task automatic wait_done(input int lat0, output int lat, output int busy_n);
    lat = lat0;
    busy_n = 0;
    while (bus.done !== 1'b1 && lat < 64) begin
      if (bus.busy === 1'b1) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_op(input string name, input logic [1:0] op, input logic src,
                          input logic [4:0] sh, input logic [31:0] rs, input logic [31:0] din,
                          input logic [31:0] exp_res, input int exp_lat);
    int lat, bn;
    issue(op, src, sh, rs, din);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(1, lat, bn);
    chk({name, ".lat"}, lat, exp_lat);
    chk({name, ".busy_cycles"}, bn, exp_lat - 1);
    chk({name, ".result"}, bus.result, exp_res);
    @(posedge clk); #1;
    chk({name, ".done_pulse"}, {31'b0, bus.done}, 32'd0);
    chk({name, ".held"}, bus.result, exp_res);
  endtask

  initial begin
    int lat, bn, dcnt;
    logic [31:0] prev;

    vecs[0] = '{2'b00, 1'b0, 5'd31, 32'h0, 32'h0000_0001, 32'h8000_0000, lat_of(31)};
    vecs[1] = '{2'b10, 1'b0, 5'd4,  32'h0, 32'h8000_0000, 32'hF800_0000, lat_of(4)};
    vecs[2] = '{2'b01, 1'b0, 5'd4,  32'h0, 32'h8000_0000, 32'h0800_0000, lat_of(4)};
    vecs[3] = '{2'b01, 1'b1, 5'd0,  32'hFFFF_FFE3, 32'h0000_00F0, 32'h0000_001E, lat_of(3)};
    vecs[4] = '{2'b00, 1'b0, 5'd0,  32'h0, 32'h1234_5678, 32'h1234_5678, lat_of(0)};
    vecs[5] = '{2'b11, 1'b0, 5'd8,  32'h0, 32'h0000_00AB, 32'h0000_AB00, lat_of(8)};
    vecs[6] = '{2'b10, 1'b0, 5'd31, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, lat_of(31)};
    vecs[7] = '{2'b10, 1'b0, 5'd5,  32'h0, 32'h7FFF_FFF0, 32'h03FF_FFFF, lat_of(5)};
    vecs[8] = '{2'b00, 1'b1, 5'd7,  32'h0000_0020, 32'hDEAD_BEEF, 32'hDEAD_BEEF, lat_of(0)};
    vecs[9] = '{2'b10, 1'b1, 5'd0,  32'hABCD_E00C, 32'hF000_0000, 32'hFFFF_0000, lat_of(12)};

    bus.start = 1'b0; bus.clr = 1'b0; bus.op = 2'b00; bus.src_sel = 1'b0;
    bus.shamt = '0; bus.rs = '0; bus.data_in = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.busy", {31'b0, bus.busy}, 32'd0);
    chk("reset.done", {31'b0, bus.done}, 32'd0);
    chk("reset.result", bus.result, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].src_sel, vecs[i].shamt,
               vecs[i].rs, vecs[i].din, vecs[i].exp_res, vecs[i].exp_lat);

    // clr and start together in IDLE: clr wins, nothing launches
    prev = bus.result;
    issue(2'b00, 1'b0, 5'd0, 32'h0, 32'h5555_AAAA);
    bus.clr = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.clr = 1'b0;
    chk("clr_start.done", {31'b0, bus.done}, 32'd0);
    chk("clr_start.result", bus.result, prev);

`ifndef SHIFT_FAST_EN
    // Abort in the second RUN cycle
    prev = bus.result;
    issue(2'b00, 1'b0, 5'd20, 32'h0, 32'h0000_0001);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("abort.run1_busy", {31'b0, bus.busy}, 32'd1);
    @(posedge clk); #1;
    bus.clr = 1'b1;
    @(posedge clk); #1;
    bus.clr = 1'b0;
    chk("abort.busy", {31'b0, bus.busy}, 32'd0);
    chk("abort.done", {31'b0, bus.done}, 32'd0);
    chk("abort.result", bus.result, prev);
    dcnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.done === 1'b1) dcnt++;
      @(posedge clk); #1;
    end
    chk("abort.no_done", dcnt, 0);

    // start during RUN is ignored
    issue(2'b00, 1'b0, 5'd20, 32'h0, 32'h0000_0001);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    issue(2'b01, 1'b0, 5'd1, 32'h0, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(3, lat, bn);
    chk("ignore.lat", lat, lat_of(20));
    chk("ignore.result", bus.result, 32'h0010_0000);
    @(posedge clk); #1;

    // reset mid-RUN
    issue(2'b00, 1'b0, 5'd31, 32'h0, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_run.busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_run.done", {31'b0, bus.done}, 32'd0);
    chk("rst_run.result", bus.result, 32'd0);
    @(posedge clk); #1;
    chk("rst_run.idle", {31'b0, bus.busy}, 32'd0);
`endif

    // Back-to-back: second start in the DONE cycle
    issue(2'b01, 1'b0, 5'd4, 32'h0, 32'h0000_00F0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(1, lat, bn);
    chk("b2b.a_lat", lat, lat_of(4));
    chk("b2b.a_result", bus.result, 32'h0000_000F);
    issue(2'b00, 1'b0, 5'd8, 32'h0, 32'h0000_000F);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(1, lat, bn);
    chk("b2b.b_lat", lat, lat_of(8));
    chk("b2b.b_result", bus.result, 32'h0000_0F00);
    @(posedge clk); #1;

    // Randomized operations against the arithmetic reference
    for (int i = 0; i < 60; i++) begin
      logic [1:0] op;
      logic src;
      logic [4:0] sh;
      logic [31:0] rs, din;
      int amt;
      op  = 2'($urandom_range(0, 3));
      src = 1'($urandom_range(0, 1));
      sh  = 5'($urandom);
      rs  = $urandom;
      din = $urandom;
      amt = src ? int'(rs[4:0]) : int'(sh);
      check_op($sformatf("rnd%0d", i), op, src, sh, rs, din, ref_shift(op, amt, din), lat_of(amt));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
